pam5_frame_decoder: RTL and testbench
=====================================

PAM5_FRAME_DECODER -- requirements
Module: pam5_frame_decoder

Interface
REQ-001 SHALL have exactly one clock; reset is asynchronous and active-high. Ports: clock  in  1  rising-edge clock; reset  in  1  async active-high reset.
REQ-002 SHALL have io_sym_valid  in  1  quartet on io_A..io_D is accepted this cycle.
REQ-003 SHALL have io_A, io_B, io_C, io_D  in  3 each  PAM5 symbols, 3-bit two's complement.
REQ-004 SHALL have io_rx_data  out  8  recovered byte.
REQ-005 SHALL have io_rx_dv  out  1  io_rx_data is frame data.
REQ-006 SHALL have io_rx_er  out  1  receive error.
REQ-007 SHALL have io_out_valid  out  1  output registers updated this cycle.
REQ-008 SHALL have io_frame_count  out  16  clean frames ended.
REQ-009 SHALL have io_err_count  out  16  error events.

Function
REQ-010 Demap per lane SHALL be: -2 (110) -> 00, -1 (111) -> 01, +1 (001) -> 10, +2 (010) -> 11; byte = {A,B,C,D}, A in [7:6].
REQ-011 A quartet with any lane in {000,011,100,101} SHALL be classed "idle".
REQ-012 Patterns (A,B,C,D) SHALL be: SSD1 = ESD1 = (+2,+2,+2,+2); SSD2 = ESD2_0 = (+2,+2,+2,-2); ESD2_1 = (+2,+2,-2,+2); ESD2_2 = (+2,-2,+2,+2); ESD2_ERR = (-2,+2,+2,+2).
REQ-013 FSM SHALL advance only on cycles with io_sym_valid=1; otherwise all state, LFSR, counters and outputs hold and io_out_valid=0.
REQ-014 States SHALL be IDLE, SSD2, DATA; reset state IDLE.
REQ-015 IDLE: quartet==SSD1 -> SSD2; else stay; outputs dv=0, er=0, data=0.
REQ-016 SSD2: quartet==SSD2 -> DATA with pend_valid=0; else -> IDLE with false-carrier output dv=0, er=1, data=8'h0E and err_count+1.
REQ-017 DATA SHALL keep a one-quartet lookahead register pend with pend_valid; first accepted data quartet loads pend and produces no dv.
REQ-018 DATA, pend_valid=1, pend==ESD1 and quartet in {ESD2_0, ESD2_1, ESD2_2}: drop pend, output dv=0 er=0, frame_count+1, -> IDLE.
REQ-019 DATA, pend_valid=1, pend==ESD1 and quartet==ESD2_ERR: drop pend, output dv=0, er=1, data=8'h1F, err_count+1, -> IDLE.
REQ-020 DATA, quartet idle-class: output pend (if pend_valid) with dv=1, er=1, err_count+1, -> IDLE; if pend_valid=0 output dv=0, er=1, data=8'h0E.
REQ-021 DATA otherwise: output demap(pend) with dv=1, er=0 (if pend_valid), then pend <= quartet, pend_valid <= 1.
REQ-022 Latency SHALL be: data of quartet k appears on outputs after the edge accepting quartet k+1.
REQ-023 All outputs SHALL be registered; io_out_valid=1 on every cycle following an accepted quartet.
REQ-024 Counters SHALL saturate at 16'hFFFF; simultaneous events impossible by construction (one event per accepted quartet).
REQ-025 An idle quartet arriving in IDLE or SSD2 SHALL follow REQ-015/REQ-016 unchanged.

Reset
REQ-026 Reset assertion SHALL immediately force: state IDLE, pend_valid 0, io_rx_data 0, io_rx_dv 0, io_rx_er 0, io_out_valid 0, both counters 0, LFSR 33'h1.
REQ-027 Reset mid-frame SHALL discard pend without a counter update; the first post-reset quartet is evaluated from IDLE.

Configuration
REQ-028 Macro PAM5_RX_DESCRAMBLE_EN defined: 33-bit LFSR, g(x)=1+x^13+x^33, seed 33'h1, shifts once per accepted quartet in every state; scrambler byte = LFSR[7:0] sampled when the quartet is accepted, stored with pend; io_rx_data = demap(pend) XOR stored byte.
REQ-029 Macro undefined: no LFSR; io_rx_data = demap(pend); reset value list omits LFSR.

Verification
REQ-030 Reset held, sym_valid=1 with SSD1 -> all outputs 0, counters 0.
REQ-031 (no descramble) SSD1, SSD2, (+1,-1,+2,-2), (-2,-2,-2,-1), ESD1, ESD2_0, valid every cycle -> dv=1 data 8'h9C then 8'h01, then dv=0, frame_count=1.
REQ-032 SSD1 then (+2,+2,0,+2) -> one cycle dv=0 er=1 data 8'h0E, err_count=1, state IDLE.
REQ-033 In DATA with pend=(+1,+1,+1,+1), quartet (0,0,0,0) -> dv=1 er=1 data 8'hAA, err_count+1, IDLE.
REQ-034 Frame ending ESD1, ESD2_ERR -> dv=0 er=1 data 8'h1F, frame_count unchanged, err_count+1; repeat with sym_valid low gaps -> identical outputs, holds during gaps.

Source files
------------

// File: rtl/pam5_frame_decoder.sv
// PAM5 quartet receiver: demaps 4-lane symbols to bytes, tracks SSD/ESD framing, counts frames and errors.
// Optional descrambling is enabled by defining PAM5_RX_DESCRAMBLE_EN.
module pam5_frame_decoder (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_sym_valid,
  input  logic [2:0]  io_A,
  input  logic [2:0]  io_B,
  input  logic [2:0]  io_C,
  input  logic [2:0]  io_D,
  output logic [7:0]  io_rx_data,
  output logic        io_rx_dv,
  output logic        io_rx_er,
  output logic        io_out_valid,
  output logic [15:0] io_frame_count,
  output logic [15:0] io_err_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_SSD2, ST_DATA} state_t;

  localparam logic [2:0]  P2 = 3'b010;
  localparam logic [2:0]  M2 = 3'b110;
  localparam logic [11:0] Q_SSD1     = {P2, P2, P2, P2};
  localparam logic [11:0] Q_SSD2     = {P2, P2, P2, M2};
  localparam logic [11:0] Q_ESD2_1   = {P2, P2, M2, P2};
  localparam logic [11:0] Q_ESD2_2   = {P2, M2, P2, P2};
  localparam logic [11:0] Q_ESD2_ERR = {M2, P2, P2, P2};

  function automatic logic [1:0] demap(input logic [2:0] s);
    case (s)
      3'b111:  demap = 2'b01;
      3'b001:  demap = 2'b10;
      3'b010:  demap = 2'b11;
      default: demap = 2'b00;
    endcase
  endfunction

  function automatic logic lane_idle(input logic [2:0] s);
    lane_idle = (s == 3'b000) || (s == 3'b011) || (s == 3'b100) || (s == 3'b101);
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  pend_q, pend_d;
  logic        pend_valid_q, pend_valid_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_dv_q, rx_dv_d;
  logic        rx_er_q, rx_er_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic [11:0] quartet;
  logic [7:0]  sym_byte;
  logic [7:0]  pend_out;
  logic        is_idle;
  logic        pend_is_esd1;
  logic        frame_inc;
  logic        err_inc;

  assign quartet  = {io_A, io_B, io_C, io_D};
  assign sym_byte = {demap(io_A), demap(io_B), demap(io_C), demap(io_D)};
  assign is_idle  = lane_idle(io_A) | lane_idle(io_B) | lane_idle(io_C) | lane_idle(io_D);
  // pend only ever holds non-idle quartets, so 8'hFF uniquely means all lanes +2 (ESD1)
  assign pend_is_esd1 = pend_valid_q && (pend_q == 8'hFF);

`ifdef PAM5_RX_DESCRAMBLE_EN
  logic [32:0] lfsr_q, lfsr_d;
  logic [7:0]  pend_scr_q, pend_scr_d;
  assign pend_out = pend_q ^ pend_scr_q;
`else
  assign pend_out = pend_q;
`endif

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    rx_data_d    = rx_data_q;
    rx_dv_d      = rx_dv_q;
    rx_er_d      = rx_er_q;
    out_valid_d  = 1'b0;
    frame_inc    = 1'b0;
    err_inc      = 1'b0;
`ifdef PAM5_RX_DESCRAMBLE_EN
    lfsr_d       = lfsr_q;
    pend_scr_d   = pend_scr_q;
`endif
    if (io_sym_valid) begin
      out_valid_d = 1'b1;
      rx_data_d   = 8'h00;
      rx_dv_d     = 1'b0;
      rx_er_d     = 1'b0;
`ifdef PAM5_RX_DESCRAMBLE_EN
      lfsr_d      = {lfsr_q[31:0], lfsr_q[32] ^ lfsr_q[12]};
`endif
      case (state_q)
        ST_IDLE: begin
          if (quartet == Q_SSD1) state_d = ST_SSD2;
        end
        ST_SSD2: begin
          if (quartet == Q_SSD2) begin
            state_d      = ST_DATA;
            pend_valid_d = 1'b0;
          end else begin
            state_d   = ST_IDLE;
            rx_er_d   = 1'b1;
            rx_data_d = 8'h0E;
            err_inc   = 1'b1;
          end
        end
        ST_DATA: begin
          if (pend_is_esd1 && (quartet == Q_SSD2 || quartet == Q_ESD2_1 ||
                               quartet == Q_ESD2_2)) begin
            state_d      = ST_IDLE;
            pend_valid_d = 1'b0;
            frame_inc    = 1'b1;
          end else if (pend_is_esd1 && quartet == Q_ESD2_ERR) begin
            state_d      = ST_IDLE;
            pend_valid_d = 1'b0;
            rx_er_d      = 1'b1;
            rx_data_d    = 8'h1F;
            err_inc      = 1'b1;
          end else if (is_idle) begin
            state_d      = ST_IDLE;
            pend_valid_d = 1'b0;
            rx_er_d      = 1'b1;
            err_inc      = 1'b1;
            rx_dv_d      = pend_valid_q;
            rx_data_d    = pend_valid_q ? pend_out : 8'h0E;
          end else begin
            rx_dv_d      = pend_valid_q;
            rx_data_d    = pend_valid_q ? pend_out : 8'h00;
            pend_d       = sym_byte;
            pend_valid_d = 1'b1;
`ifdef PAM5_RX_DESCRAMBLE_EN
            pend_scr_d   = lfsr_q[7:0];
`endif
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    frame_cnt_d = (frame_inc && frame_cnt_q != 16'hFFFF) ? frame_cnt_q + 16'd1 : frame_cnt_q;
    err_cnt_d   = (err_inc && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pend_q       <= 8'h00;
      pend_valid_q <= 1'b0;
      rx_data_q    <= 8'h00;
      rx_dv_q      <= 1'b0;
      rx_er_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_cnt_q  <= 16'h0000;
      err_cnt_q    <= 16'h0000;
`ifdef PAM5_RX_DESCRAMBLE_EN
      lfsr_q       <= 33'h1;
      pend_scr_q   <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      rx_data_q    <= rx_data_d;
      rx_dv_q      <= rx_dv_d;
      rx_er_q      <= rx_er_d;
      out_valid_q  <= out_valid_d;
      frame_cnt_q  <= frame_cnt_d;
      err_cnt_q    <= err_cnt_d;
`ifdef PAM5_RX_DESCRAMBLE_EN
      lfsr_q       <= lfsr_d;
      pend_scr_q   <= pend_scr_d;
`endif
    end
  end

  assign io_rx_data     = rx_data_q;
  assign io_rx_dv       = rx_dv_q;
  assign io_rx_er       = rx_er_q;
  assign io_out_valid   = out_valid_q;
  assign io_frame_count = frame_cnt_q;
  assign io_err_count   = err_cnt_q;

endmodule

// File: tb/tb_pam5_frame_decoder.sv
// Directed bench for pam5_frame_decoder in its default build (descrambler disabled).
module tb_pam5_frame_decoder;

  localparam logic [2:0] P2 = 3'b010;
  localparam logic [2:0] P1 = 3'b001;
  localparam logic [2:0] M1 = 3'b111;
  localparam logic [2:0] M2 = 3'b110;
  localparam logic [2:0] Z0 = 3'b000;

  logic        clock;
  logic        reset;
  logic        io_sym_valid;
  logic [2:0]  io_A, io_B, io_C, io_D;
  logic [7:0]  io_rx_data;
  logic        io_rx_dv;
  logic        io_rx_er;
  logic        io_out_valid;
  logic [15:0] io_frame_count;
  logic [15:0] io_err_count;

  int n_asserts = 0;
  int n_fail    = 0;

  pam5_frame_decoder dut (
    .clock          (clock),
    .reset          (reset),
    .io_sym_valid   (io_sym_valid),
    .io_A           (io_A),
    .io_B           (io_B),
    .io_C           (io_C),
    .io_D           (io_D),
    .io_rx_data     (io_rx_data),
    .io_rx_dv       (io_rx_dv),
    .io_rx_er       (io_rx_er),
    .io_out_valid   (io_out_valid),
    .io_frame_count (io_frame_count),
    .io_err_count   (io_err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of input, then sample 1 time unit after the accepting edge.
  task automatic step(input logic v, input logic [2:0] a, b, c, d);
    io_sym_valid = v;
    io_A = a; io_B = b; io_C = c; io_D = d;
    @(posedge clock);
    #1;
    $display("t=%0t v=%0b q=%b_%b_%b_%b -> ov=%0b dv=%0b er=%0b data=%h frames=%0d errs=%0d",
             $time, v, a, b, c, d, io_out_valid, io_rx_dv, io_rx_er, io_rx_data,
             io_frame_count, io_err_count);
  endtask

  task automatic chk_out(input string tag, input logic ov, input logic dv, input logic er,
                         input logic [7:0] data);
    chk({tag, ".ov"}, {15'd0, io_out_valid}, {15'd0, ov});
    chk({tag, ".dv"}, {15'd0, io_rx_dv}, {15'd0, dv});
    chk({tag, ".er"}, {15'd0, io_rx_er}, {15'd0, er});
    chk({tag, ".data"}, {8'd0, io_rx_data}, {8'd0, data});
  endtask

  initial begin
    reset = 1'b1;
    io_sym_valid = 1'b1;
    io_A = P2; io_B = P2; io_C = P2; io_D = P2;

    // Reset held with SSD1 offered
    repeat (3) step(1'b1, P2, P2, P2, P2);
    chk_out("rst", 1'b0, 1'b0, 1'b0, 8'h00);
    chk("rst.frames", io_frame_count, 16'd0);
    chk("rst.errs", io_err_count, 16'd0);
    reset = 1'b0;

    // Clean two-byte frame
    step(1'b1, P2, P2, P2, P2);
    chk_out("a.ssd1", 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, P2, P2, P2, M2);
    chk_out("a.ssd2", 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, P1, M1, P2, M2);
    chk_out("a.d0", 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, M2, M2, M2, M1);
    chk_out("a.d1", 1'b1, 1'b1, 1'b0, 8'h9C);
    step(1'b1, P2, P2, P2, P2);
    chk_out("a.esd1", 1'b1, 1'b1, 1'b0, 8'h01);
    step(1'b1, P2, P2, P2, M2);
    chk("a.esd2.ov", {15'd0, io_out_valid}, 16'd1);
    chk("a.esd2.dv", {15'd0, io_rx_dv}, 16'd0);
    chk("a.esd2.er", {15'd0, io_rx_er}, 16'd0);
    chk("a.frames", io_frame_count, 16'd1);
    chk("a.errs", io_err_count, 16'd0);
    step(1'b0, Z0, Z0, Z0, Z0);
    chk("a.gap.ov", {15'd0, io_out_valid}, 16'd0);
    chk("a.gap.frames", io_frame_count, 16'd1);

    // False carrier: SSD1 followed by an idle quartet
    step(1'b1, P2, P2, P2, P2);
    step(1'b1, P2, P2, Z0, P2);
    chk_out("b.fc", 1'b1, 1'b0, 1'b1, 8'h0E);
    chk("b.errs", io_err_count, 16'd1);
    // Back in IDLE: another idle quartet raises no error
    step(1'b1, P2, P2, Z0, P2);
    chk_out("b.idle", 1'b1, 1'b0, 1'b0, 8'h00);
    chk("b.errs2", io_err_count, 16'd1);

    // Idle quartet mid-frame flushes pend with er
    step(1'b1, P2, P2, P2, P2);
    step(1'b1, P2, P2, P2, M2);
    step(1'b1, P1, P1, P1, P1);
    step(1'b1, Z0, Z0, Z0, Z0);
    chk_out("c.abort", 1'b1, 1'b1, 1'b1, 8'hAA);
    chk("c.errs", io_err_count, 16'd2);
    step(1'b1, Z0, Z0, Z0, Z0);
    chk_out("c.idle", 1'b1, 1'b0, 1'b0, 8'h00);
    chk("c.errs2", io_err_count, 16'd2);

    // ESD2_ERR frame end
    step(1'b1, P2, P2, P2, P2);
    step(1'b1, P2, P2, P2, M2);
    step(1'b1, P2, M1, P1, M2);
    step(1'b1, P2, P2, P2, P2);
    chk_out("d.esd1", 1'b1, 1'b1, 1'b0, 8'hD8);
    step(1'b1, M2, P2, P2, P2);
    chk_out("d.esderr", 1'b1, 1'b0, 1'b1, 8'h1F);
    chk("d.frames", io_frame_count, 16'd1);
    chk("d.errs", io_err_count, 16'd3);

    // Same frame with gaps between every quartet
    step(1'b1, P2, P2, P2, P2);
    step(1'b0, P2, P2, P2, M2);
    step(1'b1, P2, P2, P2, M2);
    step(1'b0, Z0, Z0, Z0, Z0);
    step(1'b1, P2, M1, P1, M2);
    step(1'b0, M2, P2, P2, P2);
    chk_out("e.gap0", 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, P2, P2, P2, P2);
    chk_out("e.esd1", 1'b1, 1'b1, 1'b0, 8'hD8);
    step(1'b0, Z0, Z0, Z0, Z0);
    chk_out("e.gap1", 1'b0, 1'b1, 1'b0, 8'hD8);
    step(1'b1, M2, P2, P2, P2);
    chk_out("e.esderr", 1'b1, 1'b0, 1'b1, 8'h1F);
    step(1'b0, P2, P2, P2, P2);
    chk_out("e.gap2", 1'b0, 1'b0, 1'b1, 8'h1F);
    chk("e.frames", io_frame_count, 16'd1);
    chk("e.errs", io_err_count, 16'd4);

    // ESD1 as ordinary data, then ESD2_1 end
    step(1'b1, P2, P2, P2, P2);
    step(1'b1, P2, P2, P2, M2);
    step(1'b1, P2, P2, P2, P2);
    chk_out("f.pend", 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, M2, M2, M2, M2);
    chk_out("f.ff", 1'b1, 1'b1, 1'b0, 8'hFF);
    step(1'b1, P2, P2, P2, P2);
    chk_out("f.00", 1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b1, P2, P2, M2, P2);
    chk("f.dv", {15'd0, io_rx_dv}, 16'd0);
    chk("f.frames", io_frame_count, 16'd2);

    // Empty frame ended by ESD2_2
    step(1'b1, P2, P2, P2, P2);
    step(1'b1, P2, P2, P2, M2);
    step(1'b1, P2, P2, P2, P2);
    step(1'b1, P2, M2, P2, P2);
    chk("g.dv", {15'd0, io_rx_dv}, 16'd0);
    chk("g.er", {15'd0, io_rx_er}, 16'd0);
    chk("g.frames", io_frame_count, 16'd3);
    chk("g.errs", io_err_count, 16'd4);

    // Non-SSD2 after SSD1 is a false carrier
    step(1'b1, P2, P2, P2, P2);
    step(1'b1, P2, P2, P2, P2);
    chk_out("h.fc", 1'b1, 1'b0, 1'b1, 8'h0E);
    chk("h.errs", io_err_count, 16'd5);

    // Asynchronous reset mid-frame discards pend
    step(1'b1, P2, P2, P2, P2);
    step(1'b1, P2, P2, P2, M2);
    step(1'b1, P1, P1, P1, P1);
    step(1'b1, M1, M1, M1, M1);
    chk_out("i.pre", 1'b1, 1'b1, 1'b0, 8'hAA);
    reset = 1'b1;
    #2;
    chk_out("i.rst", 1'b0, 1'b0, 1'b0, 8'h00);
    chk("i.frames", io_frame_count, 16'd0);
    chk("i.errs", io_err_count, 16'd0);
    reset = 1'b0;
    step(1'b1, M2, M2, M2, M2);
    chk_out("i.post", 1'b1, 1'b0, 1'b0, 8'h00);
    chk("i.errs2", io_err_count, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
